// File: rtl/ccg_bist_sig_engine.sv
// BIST harness: drives a combinational (optionally pipelined) circuit from an
// LFSR or exhaustive counter and compacts its responses into a MISR signature.
module ccg_bist_sig_engine #(
    parameter int                N_IN      = 9,
    parameter int                N_OUT     = 12,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY = 16'hB400,
    parameter int                SIG_W     = 32,
    parameter logic [SIG_W-1:0]  SIG_POLY  = 32'h04C11DB7,
    parameter int                CNT_W     = 16,
    parameter int                DUT_LAT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_vec,
    output logic [N_IN-1:0]   x,
    input  logic [N_OUT-1:0]  f,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  vec_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic               mode_q;
    logic [LFSR_W-1:0]  stim;
    logic [CNT_W-1:0]   rem;
    logic [1:0]         flush_cnt;

    logic [LFSR_W-1:0]  stim_lfsr;
    logic [LFSR_W-1:0]  stim_cnt;
    logic [LFSR_W-1:0]  stim_nxt;
    logic [LFSR_W-1:0]  stim_load;
    logic [N_IN-1:0]    cnt_inc;
    logic [SIG_W-1:0]   f_ext;
    logic [SIG_W-1:0]   misr_nxt;
    logic               running;
    logic               cap;

    assign running = (state == RUN);

    always_comb begin
        stim_lfsr = (stim >> 1) ^ (stim[0] ? LFSR_POLY : '0);
        cnt_inc   = stim[N_IN-1:0] + N_IN'(1);
        stim_cnt  = '0;
        stim_cnt[N_IN-1:0] = cnt_inc;
        stim_nxt  = mode_q ? stim_cnt : stim_lfsr;

        // an all-zero LFSR state would lock up, so seed 0 becomes 1
        stim_load = '0;
        if (mode) begin
            stim_load[N_IN-1:0] = seed[N_IN-1:0];
        end else if (seed == '0) begin
            stim_load = LFSR_W'(1);
        end else begin
            stim_load = seed;
        end

        f_ext = '0;
        f_ext[N_OUT-1:0] = f;
        misr_nxt = {signature[SIG_W-2:0], 1'b0}
                 ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                 ^ f_ext;
    end

    // capture strobe follows "vector driven" through the circuit's pipe depth
    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign cap = running;
        end else begin : g_lat
            logic [DUT_LAT-1:0] vsh;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vsh <= '0;
                end else begin
                    vsh <= (vsh << 1) | DUT_LAT'(running);
                end
            end
            assign cap = vsh[DUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            stim      <= '0;
            rem       <= '0;
            flush_cnt <= '0;
            x         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
            vec_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (cap) begin
                signature <= misr_nxt;
                vec_cnt   <= vec_cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        rem       <= num_vec;
                        stim      <= stim_load;
                        x         <= stim_load[N_IN-1:0];
                        signature <= '0;
                        vec_cnt   <= '0;
                        if (num_vec == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rem == CNT_W'(1)) begin
                        if (DUT_LAT == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= 2'(DUT_LAT - 1);
                        end
                    end else begin
                        rem  <= rem - CNT_W'(1);
                        stim <= stim_nxt;
                        x    <= stim_nxt[N_IN-1:0];
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ccg_bist_sig_engine.md
Name: ccg_bist_sig_engine

Overview:
- Parametrised, clocked stimulus/response harness for generated combinational benchmark circuits.
- Drives the circuit input bus x from either an LFSR or an exhaustive counter.
- Compacts the circuit output bus f into a MISR signature.
- Used to fingerprint netlist variants (original vs. balanced) in hardware. Generalises the fixed 9-in/12-out benchmark shape to arbitrary widths and pipelined circuits.

Parameters:
- N_IN, 9, width of x (1..LFSR_W)
- N_OUT, 12, width of f (1..SIG_W)
- LFSR_W, 16, stimulus LFSR width
- LFSR_POLY, 16'hB400, Galois LFSR feedback mask
- SIG_W, 32, MISR width
- SIG_POLY, 32'h04C11DB7, MISR feedback mask
- CNT_W, 16, vector counter width
- DUT_LAT, 0, register stages inside the circuit under test (0..3)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  run request, sampled in IDLE only
- mode  in  1  0 = LFSR stimulus, 1 = exhaustive counter
- seed  in  LFSR_W  initial stimulus state
- num_vec  in  CNT_W  number of vectors to apply
- x  out  N_IN  stimulus to the circuit (registered)
- f  in  N_OUT  circuit response
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, signature final
- signature  out  SIG_W  MISR contents
- vec_cnt  out  CNT_W  number of responses compacted

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State = IDLE; x, busy, done, signature, vec_cnt and all internal state go to 0.
  - Reset applies from any state; an in-progress run is discarded.
- States: IDLE, RUN, FLUSH.
- IDLE with start=1 at edge t0:
  - Latch mode and num_vec, clear the MISR and vec_cnt.
  - Load stim: LFSR mode loads seed, or 1 if seed==0. Counter mode loads seed[N_IN-1:0].
  - If num_vec==0: stay IDLE, assert done for the cycle after t0, signature = 0.
  - Otherwise go to RUN.
- RUN:
  - busy=1. x = stim[N_IN-1:0]; vector k (k=0..num_vec-1) is driven during cycle t0+1+k.
  - Stim advance, LFSR mode: stim = (stim>>1) ^ (stim[0] ? LFSR_POLY : 0).
  - Stim advance, counter mode: x increments modulo 2^N_IN (wraps 2^N_IN-1 -> 0).
  - After the last vector, go to FLUSH if DUT_LAT>0, else IDLE.
- Capture valid is a DUT_LAT-deep shift of "vector driven". On each valid edge:
  - misr = (misr<<1) ^ (misr[SIG_W-1] ? SIG_POLY : 0) ^ zero-extend(f).
  - vec_cnt increments.
- FLUSH: busy=1, x holds the last vector, lasts exactly DUT_LAT cycles, then IDLE.
- Completion: done=1 and busy=0 in cycle t0+num_vec+DUT_LAT+1. signature and vec_cnt then hold until the next accepted start.
- start handling:
  - start while busy is ignored.
  - start in the done cycle is accepted (state is IDLE).
  - mode, seed and num_vec changes while busy have no effect.
- x holds its last value in IDLE after a run.
- signature is visible (updating) during RUN/FLUSH.
- No overflow: vec_cnt ≤ num_vec ≤ 2^CNT_W-1.

Test Plan:
- Exhaustive, defaults:
  - Stimulus: mode=1, seed=0, num_vec=512, f tied to 0.
  - Required: x walks 0..511 in cycles t0+1..t0+512; done at t0+513; signature=0; vec_cnt=512.
- Compaction arithmetic:
  - Stimulus: f=12'h001, num_vec=1 -> required signature=32'h00000001.
  - Stimulus: f=12'h001, num_vec=2 -> required signature=32'h00000003.
  - Stimulus: f=12'h800, num_vec=1 -> required signature=32'h00000800.
- LFSR seed handling:
  - Stimulus: mode=0, seed=0, num_vec=3.
  - Required: x sequence = 9'h001, 9'h000, 9'h000 (stim 1 -> 16'hB400 -> 16'h5A00).
- Latency:
  - Stimulus: DUT_LAT=2; bench models a 2-stage pipe returning f = {3'b0, x delayed 2}; num_vec=3, counter mode, seed=5.
  - Required: done at t0+6; signature equals the model MISR over f = 5, 6, 7; vec_cnt=3.
- Control corners:
  - Stimulus: num_vec=0 -> required: done pulse at t0+1, busy never high.
  - Stimulus: start held high through a run -> required: ignored while busy; a new run starts in the done cycle.
  - Stimulus: rst_n=0 for one edge mid-RUN -> required: next cycle busy=0, done=0, signature=0, vec_cnt=0, x=0.
